// File: rtl/stack_segment_load_controller_if.sv
// Memory bus between the SS load controller (master) and the memory system (slave).
interface stack_segment_load_controller_if;
    logic        mem_request;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic [31:0] mem_read_data;

    modport master (
        output mem_request, mem_write, mem_address, mem_write_data,
        input  mem_ready, mem_read_data
    );

    modport slave (
        input  mem_request, mem_write, mem_address, mem_write_data,
        output mem_ready, mem_read_data
    );
endinterface

// File: rtl/stack_segment_load_controller.sv
// Stack segment (SS) load sequencer: real-mode descriptor synthesis, or protected-mode
// descriptor fetch, validation, accessed-bit update and commit to the SS register/cache.
//
// state        | meaning
// IDLE         | waiting for load_request; latches selector, cpl and table
// CHECK        | real-mode build, or selector null/limit/RPL checks
// READ_LOW     | fetch descriptor dword 0
// READ_HIGH    | fetch descriptor dword 1
// VALIDATE     | type, DPL and present checks
// SET_ACCESSED | write back upper dword with accessed bit set
// COMMIT       | one-cycle SS selector and descriptor write
// FAULT        | one-cycle fault report
module stack_segment_load_controller (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  i_load_request,
    input  logic [15:0]                           i_load_selector,
    input  logic                                  i_protected_mode,
    input  logic [1:0]                            i_cpl,
    input  logic [31:0]                           i_gdt_base,
    input  logic [31:0]                           i_ldt_base,
    input  logic [15:0]                           i_gdt_limit,
    input  logic [15:0]                           i_ldt_limit,
    stack_segment_load_controller_if.master       mem,
    output logic                                  o_ss_write_enable,
    output logic [15:0]                           o_ss_write_data,
    output logic                                  o_ss_descriptor_write_enable,
    output logic [63:0]                           o_ss_descriptor_write_data,
    output logic                                  o_load_busy,
    output logic                                  o_load_done,
    output logic                                  o_load_fault,
    output logic [7:0]                            o_fault_vector,
    output logic [15:0]                           o_fault_error_code
);

    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] CHECK        = 3'd1;
    localparam logic [2:0] READ_LOW     = 3'd2;
    localparam logic [2:0] READ_HIGH    = 3'd3;
    localparam logic [2:0] VALIDATE     = 3'd4;
    localparam logic [2:0] SET_ACCESSED = 3'd5;
    localparam logic [2:0] COMMIT       = 3'd6;
    localparam logic [2:0] FAULT        = 3'd7;

    localparam logic [7:0] VEC_GP = 8'd13;
    localparam logic [7:0] VEC_SS = 8'd12;

    logic [2:0]  r_state;
    logic [15:0] r_selector;
    logic [1:0]  r_cpl;
    logic        r_pm;
    logic [31:0] r_tbl_base;
    logic [15:0] r_tbl_limit;
    logic [31:0] r_desc_addr;
    logic [63:0] r_desc;
    logic [7:0]  r_fault_vector;
    logic [15:0] r_fault_code;

    logic        w_null;
    logic        w_over_limit;
    logic        w_rpl_bad;
    logic [15:0] w_err_code;
    logic        w_type_bad;
    logic        w_dpl_bad;
    logic        w_not_present;
    logic [31:0] w_desc_addr;
    logic [31:0] w_real_base;
    logic        w_mem_cycle;
    logic        w_ack;

    assign w_null        = (r_selector[15:2] == 14'd0);
    assign w_over_limit  = ({r_selector[15:3], 3'b111} > r_tbl_limit);
    assign w_rpl_bad     = (r_selector[1:0] != r_cpl);
    assign w_err_code    = r_selector & 16'hFFFC;
    assign w_type_bad    = !r_desc[44] || r_desc[43] || !r_desc[41];
    assign w_dpl_bad     = (r_desc[46:45] != r_cpl);
    assign w_not_present = !r_desc[47];
    assign w_desc_addr   = r_tbl_base + {16'd0, r_selector[15:3], 3'b000};
    assign w_real_base   = {12'd0, r_selector, 4'd0};

    // Request is a pure decode of the state, so it and the address stay stable through wait states.
    assign w_mem_cycle = (r_state == READ_LOW) || (r_state == READ_HIGH) || (r_state == SET_ACCESSED);
    assign w_ack       = w_mem_cycle && mem.mem_ready;

    assign mem.mem_request    = w_mem_cycle;
    assign mem.mem_write      = (r_state == SET_ACCESSED);
    assign mem.mem_address    = (r_state == READ_LOW) ? r_desc_addr :
                                ((r_state == READ_HIGH) || (r_state == SET_ACCESSED)) ? (r_desc_addr + 32'd4) :
                                32'd0;
    assign mem.mem_write_data = (r_state == SET_ACCESSED) ? (r_desc[63:32] | 32'h0000_0100) : 32'd0;

    assign o_load_busy                  = (r_state != IDLE);
    assign o_load_done                  = (r_state == COMMIT);
    assign o_load_fault                 = (r_state == FAULT);
    assign o_ss_write_enable            = (r_state == COMMIT);
    assign o_ss_descriptor_write_enable = (r_state == COMMIT);
    assign o_ss_write_data              = (r_state == COMMIT) ? r_selector : 16'd0;
    assign o_ss_descriptor_write_data   = (r_state == COMMIT) ? r_desc : 64'd0;
    assign o_fault_vector               = (r_state == FAULT) ? r_fault_vector : 8'd0;
    assign o_fault_error_code           = (r_state == FAULT) ? r_fault_code : 16'd0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_selector     <= 16'd0;
            r_cpl          <= 2'd0;
            r_pm           <= 1'b0;
            r_tbl_base     <= 32'd0;
            r_tbl_limit    <= 16'd0;
            r_desc_addr    <= 32'd0;
            r_desc         <= 64'd0;
            r_fault_vector <= 8'd0;
            r_fault_code   <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load_request) begin
                        r_selector  <= i_load_selector;
                        r_cpl       <= i_cpl;
                        r_pm        <= i_protected_mode;
                        r_tbl_base  <= i_load_selector[2] ? i_ldt_base : i_gdt_base;
                        r_tbl_limit <= i_load_selector[2] ? i_ldt_limit : i_gdt_limit;
                        r_desc      <= 64'd0;
                        r_state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (!r_pm) begin
                        r_desc  <= {w_real_base[31:24], 8'h00, 8'h93, w_real_base[23:0], 16'hFFFF};
                        r_state <= COMMIT;
                    end else if (w_null) begin
                        r_fault_vector <= VEC_GP;
                        r_fault_code   <= 16'd0;
                        r_state        <= FAULT;
                    end else if (w_over_limit || w_rpl_bad) begin
                        r_fault_vector <= VEC_GP;
                        r_fault_code   <= w_err_code;
                        r_state        <= FAULT;
                    end else begin
                        r_desc_addr <= w_desc_addr;
                        r_state     <= READ_LOW;
                    end
                end
                READ_LOW: begin
                    if (w_ack) begin
                        r_desc[31:0] <= mem.mem_read_data;
                        r_state      <= READ_HIGH;
                    end
                end
                READ_HIGH: begin
                    if (w_ack) begin
                        r_desc[63:32] <= mem.mem_read_data;
                        r_state       <= VALIDATE;
                    end
                end
                VALIDATE: begin
                    if (w_type_bad || w_dpl_bad) begin
                        r_fault_vector <= VEC_GP;
                        r_fault_code   <= w_err_code;
                        r_state        <= FAULT;
                    end else if (w_not_present) begin
                        r_fault_vector <= VEC_SS;
                        r_fault_code   <= w_err_code;
                        r_state        <= FAULT;
                    end else if (r_desc[40]) begin
                        r_state <= COMMIT;
                    end else begin
                        r_state <= SET_ACCESSED;
                    end
                end
                SET_ACCESSED: begin
                    if (w_ack) begin
                        r_desc[40] <= 1'b1;
                        r_state    <= COMMIT;
                    end
                end
                COMMIT:  r_state <= IDLE;
                FAULT:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
